// File: rtl/ppu_oam_dma.sv
// OAM DMA engine for the PPU.
//
// This block snoops CPU writes to DMA_REG. A write received while idle halts
// the CPU and copies one 256-byte CPU page into the PPU OAMDATA register. Each
// byte uses one READ cycle from {page, cnt} and then one WRITE cycle to
// OAM_DATA_REG. READ cycles always start on an even cycle, where r_odd == 0.
// When the HALT cycle lands on an even cycle, one ALIGN cycle is inserted.
//
// Ports
//   i_cpu_clk     single clock for all logic
//   i_cpu_rst     synchronous active-high reset
//   i_bus_addr    CPU-side bus address, snooped before the bus mux
//   i_bus_wn      CPU-side write strobe, 0 = write
//   i_bus_wdata   CPU-side write data, which carries the page on a trigger
//   i_bus_rdata   shared-bus read data, valid in the same cycle as the address
//   o_cpu_halt    stalls the CPU while a transfer is pending or running
//   o_dma_active  bus-mux select, 1 = DMA owns addr/wn/wdata
//   o_dma_addr    DMA bus address
//   o_dma_wn      DMA write strobe, 0 = write
//   o_dma_wdata   DMA write data
//   o_dma_done    one-cycle pulse in the first idle cycle after a full transfer
module ppu_oam_dma #(
  parameter logic [15:0] DMA_REG      = 16'h4014,
  parameter logic [15:0] OAM_DATA_REG = 16'h2004
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rst,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_cpu_halt,
  output logic        o_dma_active,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata,
  output logic        o_dma_done
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StAlign = 3'd2,
    StRead  = 3'd3,
    StWrite = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       r_odd_q;

  always_ff @(posedge i_cpu_clk) begin
    if (i_cpu_rst) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      r_odd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      r_odd_q <= ~r_odd_q;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if ((i_bus_addr == DMA_REG) && !i_bus_wn) begin
          page_d  = i_bus_wdata;
          cnt_d   = 8'h00;
          state_d = StHalt;
        end
      end
      // r_odd_q == 1 here means the next cycle is even and can be a READ.
      StHalt:  state_d = r_odd_q ? StRead : StAlign;
      StAlign: state_d = StRead;
      StRead: begin
        data_d  = i_bus_rdata;
        state_d = StWrite;
      end
      StWrite: begin
        if (cnt_q == 8'hFF) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Every output is a decode of registered state.
  always_comb begin
    o_cpu_halt   = (state_q != StIdle);
    o_dma_active = 1'b0;
    o_dma_addr   = 16'h0000;
    o_dma_wn     = 1'b1;
    o_dma_wdata  = 8'h00;
    o_dma_done   = done_q;
    case (state_q)
      StRead: begin
        o_dma_active = 1'b1;
        o_dma_addr   = {page_q, cnt_q};
      end
      StWrite: begin
        o_dma_active = 1'b1;
        o_dma_addr   = OAM_DATA_REG;
        o_dma_wn     = 1'b0;
        o_dma_wdata  = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ppu_oam_dma.sv
module tb_ppu_oam_dma;

  localparam logic [15:0] DmaReg = 16'h4014;
  localparam logic [15:0] OamReg = 16'h2004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_wn = 1'b1;
  logic [7:0]  bus_wdata = 8'h00;
  logic [7:0]  bus_rdata;
  logic        halt, active, dma_wn, done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        ph = 1'b0;  // expected r_odd for the current cycle

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ph <= rst ? 1'b0 : ~ph;

  // Memory model: page 07 holds i ^ 5A, and every other page holds i ^ page.
  function automatic logic [7:0] mem(input logic [15:0] a);
    if (a[15:8] == 8'h07) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ a[15:8];
  endfunction

  assign bus_rdata = mem(dma_addr);

  ppu_oam_dma #(
    .DMA_REG      (DmaReg),
    .OAM_DATA_REG (OamReg)
  ) dut (
    .i_cpu_clk    (clk),
    .i_cpu_rst    (rst),
    .i_bus_addr   (bus_addr),
    .i_bus_wn     (bus_wn),
    .i_bus_wdata  (bus_wdata),
    .i_bus_rdata  (bus_rdata),
    .o_cpu_halt   (halt),
    .o_dma_active (active),
    .o_dma_addr   (dma_addr),
    .o_dma_wn     (dma_wn),
    .o_dma_wdata  (dma_wdata),
    .o_dma_done   (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one transfer, with the trigger placed in a cycle whose parity is par.
  task automatic run_xfer(input string tag, input logic [7:0] page, input logic par,
                          input bit inject, input int exp_halt,
                          output logic [7:0] first_w, output logic [15:0] last_raddr);
    int halt_len = 0, rd_idx = 0, wr_idx = 0, rd_bad = 0, wr_bad = 0, misc_bad = 0;
    int n = 0;
    first_w = 8'h00;
    last_raddr = 16'h0000;
    while (ph !== par && n < 4) begin
      @(negedge clk);
      n++;
    end
    bus_addr = DmaReg; bus_wn = 1'b0; bus_wdata = page;
    @(negedge clk);
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (!halt) break;
      halt_len++;
      if (inject && cyc == 100) begin
        bus_addr = DmaReg; bus_wn = 1'b0; bus_wdata = 8'h03;
      end else begin
        bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
      end
      if (done) misc_bad++;
      if (active && dma_wn) begin
        if (dma_addr !== {page, 8'(rd_idx)}) rd_bad++;
        if (rd_idx == 0 && ph !== 1'b0) rd_bad++;
        if (rd_idx != wr_idx) rd_bad++;
        last_raddr = dma_addr;
        rd_idx++;
      end else if (active) begin
        if (dma_addr !== OamReg) wr_bad++;
        if (dma_wdata !== mem({page, 8'(wr_idx)})) wr_bad++;
        if (wr_idx != rd_idx - 1) wr_bad++;
        if (wr_idx == 0) first_w = dma_wdata;
        wr_idx++;
      end else begin
        if (dma_addr !== 16'h0000 || dma_wn !== 1'b1 || dma_wdata !== 8'h00) misc_bad++;
        if (rd_idx != 0) misc_bad++;
      end
      @(negedge clk);
    end
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    check({tag, " halt_len"}, halt_len, exp_halt);
    check({tag, " reads"}, rd_idx, 256);
    check({tag, " writes"}, wr_idx, 256);
    check({tag, " read_errs"}, rd_bad, 0);
    check({tag, " write_errs"}, wr_bad, 0);
    check({tag, " misc_errs"}, misc_bad, 0);
    check({tag, " done_pulse"}, done, 1);
    check({tag, " end_idle"}, {halt, active, dma_wn, dma_addr, dma_wdata}, {2'b00, 1'b1, 24'h0});
    @(negedge clk);
    check({tag, " done_drop"}, done, 0);
    check({tag, " stay_idle"}, halt, 0);
  endtask

  initial begin
    logic [7:0]  fw;
    logic [15:0] lra;
    int wcnt, stray;

    repeat (3) @(negedge clk);
    check("rst halt", halt, 0);
    check("rst active", active, 0);
    check("rst addr", dma_addr, 16'h0000);
    check("rst wn", dma_wn, 1);
    check("rst wdata", dma_wdata, 8'h00);
    check("rst done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle no_halt", halt, 0);

    run_xfer("even p02", 8'h02, 1'b0, 1'b0, 513, fw, lra);
    run_xfer("odd p02", 8'h02, 1'b1, 1'b0, 514, fw, lra);
    run_xfer("p07", 8'h07, 1'b0, 1'b0, 513, fw, lra);
    check("p07 first_byte", fw, 8'h5A);
    run_xfer("retrig p02", 8'h02, 1'b1, 1'b1, 514, fw, lra);

    // Reset in the WRITE cycle with cnt == 80.
    bus_addr = DmaReg; bus_wn = 1'b0; bus_wdata = 8'h04;
    @(negedge clk);
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    wcnt = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (active && !dma_wn) begin
        if (wcnt == 8'h80) break;
        wcnt++;
      end
      @(negedge clk);
    end
    check("mid write_reached", {active, dma_wn, 8'(wcnt)}, {2'b10, 8'h80});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid halt", halt, 0);
    check("mid active", active, 0);
    check("mid addr", dma_addr, 16'h0000);
    check("mid done", done, 0);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (active || done || halt) stray++;
    end
    check("mid quiet", stray, 0);
    run_xfer("after_rst p04", 8'h04, 1'b0, 1'b0, 513, fw, lra);

    run_xfer("pFF", 8'hFF, 1'b1, 1'b0, 514, fw, lra);
    check("pFF last_read", lra, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_oam_dma.md
PPU_OAM_DMA -- requirements
Module: ppu_oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG, default 16'h4014, meaning CPU address that triggers a DMA.
REQ-002 SHALL have parameter OAM_DATA_REG, default 16'h2004, meaning PPU OAMDATA address targeted by DMA writes.
REQ-003 i_cpu_clk  input  1  single clock for all logic.
REQ-004 i_cpu_rst  input  1  reset, synchronous, active-high.
REQ-005 i_bus_addr  input  16  CPU-side bus address, snooped before the bus mux.
REQ-006 i_bus_wn  input  1  CPU-side write strobe, 0 = write.
REQ-007 i_bus_wdata  input  8  CPU-side write data.
REQ-008 i_bus_rdata  input  8  shared-bus read data, valid in the same cycle as the address.
REQ-009 o_cpu_halt  output  1  stalls the CPU while a transfer is pending or running.
REQ-010 o_dma_active  output  1  bus-mux select: 1 = DMA owns addr/wn/wdata.
REQ-011 o_dma_addr  output  16  DMA bus address.
REQ-012 o_dma_wn  output  1  DMA write strobe, 0 = write.
REQ-013 o_dma_wdata  output  8  DMA write data.
REQ-014 o_dma_done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-015 SHALL keep free-running parity bit r_odd, reset 0, toggling every cycle.
REQ-016 SHALL use FSM states IDLE, HALT, ALIGN, READ, WRITE.
REQ-017 Trigger: in IDLE, i_bus_addr==DMA_REG with i_bus_wn==0 SHALL latch i_bus_wdata as page and enter HALT next cycle.
REQ-018 Trigger writes SHALL be ignored in every state other than IDLE.
REQ-019 HALT lasts 1 cycle; from HALT: if r_odd==1, go to READ; else go to ALIGN. Every READ therefore starts with r_odd==0.
REQ-020 ALIGN lasts 1 cycle, then goes to READ.
REQ-021 READ: o_dma_addr={page,cnt}, o_dma_wn=1; i_bus_rdata SHALL be latched into the data register at the end of the cycle; next state is WRITE.
REQ-022 WRITE: o_dma_addr=OAM_DATA_REG, o_dma_wn=0, o_dma_wdata=latched byte.
REQ-023 From WRITE: if cnt==8'hFF, go to IDLE; else increment cnt and go to READ.
REQ-024 cnt SHALL be 8 bits, cleared on entry to HALT, and SHALL never wrap within a transfer.
REQ-025 A transfer SHALL be exactly 512 READ/WRITE cycles; total halt time SHALL be 513 cycles (ALIGN skipped) or 514 cycles (ALIGN taken).
REQ-026 o_cpu_halt SHALL be 1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE; all outputs are registered state decodes.
REQ-027 o_dma_active SHALL be 1 only in READ and WRITE.
REQ-028 Outside READ and WRITE: o_dma_addr=16'h0000, o_dma_wn=1, o_dma_wdata=8'h00.
REQ-029 o_dma_done SHALL be 1 for exactly the first IDLE cycle after the final WRITE.
REQ-030 The byte order at OAM SHALL be page offset 00..FF; OAM address auto-increment is owned by the PPU register block, not by this block.
REQ-031 Page 8'hFF SHALL read 16'hFF00..16'hFFFF with no carry into other pages.

Reset
REQ-032 On i_cpu_rst=1 at a clock edge: state=IDLE, page=0, cnt=0, data=0, r_odd=0, and all outputs at the REQ-028 values with o_cpu_halt=0, o_dma_active=0, o_dma_done=0.
REQ-033 Reset asserted mid-transfer SHALL abort it with no further bus writes and no o_dma_done pulse.

Verification
REQ-034 Write 8'h02 to 16'h4014 with r_odd==0 in the trigger cycle -> HALT then READ (no ALIGN); reads 16'h0200..16'h02FF alternate with writes to 16'h2004; halt lasts 513 cycles; done pulses once.
REQ-035 Same trigger one cycle later (opposite parity) -> ALIGN inserted; halt lasts 514 cycles; first READ occurs with r_odd==0.
REQ-036 Model memory page 8'h07 with data[i]=i^8'h5A -> the 256 $2004 writes carry 8'h5A, 8'h5B, ... in offset order.
REQ-037 Second $4014 write (page 8'h03) during an active transfer -> ignored; all reads stay in the original page.
REQ-038 Reset asserted at cnt==8'h80 in WRITE -> next cycle IDLE, halt=0, active=0, addr=16'h0000; no done pulse; a new trigger then runs a full 256-byte transfer.
REQ-039 Page 8'hFF trigger -> last READ address is 16'hFFFF, followed by one final WRITE and then IDLE.
